// File: rtl/bf16_seg_scan_ctrl.sv
// Multiplexed hex seven-segment scan controller with tear-free frame updates and overflow blink.
// Optional build macro SEG_LEADING_ZERO_BLANK_EN blanks digits above the highest non-zero nibble.
module bf16_seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLINK_FRAMES = 250
) (
  input  logic                    clk_100MHz,
  input  logic                    reset,
  input  logic                    dm_write,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic                    ov_in,
  output logic [0:6]              seg,
  output logic [NUM_DIGITS-1:0]   digit,
  output logic                    ov,
  output logic                    pending
);

  localparam int unsigned DATA_W = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

  logic [CNT_W-1:0]  refresh_cnt;
  logic [IDX_W-1:0]  digit_idx;
  logic [FRM_W-1:0]  frame_cnt;
  logic              blink;
  logic [DATA_W-1:0] shadow;
  logic              shadow_ov;
  logic [DATA_W-1:0] disp;

  logic              tick_c;
  logic              frame_end_c;
  logic [3:0]        nibble_c;
  logic              blank_c;
`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [IDX_W-1:0]  top_idx_c;
`endif

  // Hex to active-low a..g, leftmost bit is segment a.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // Scan timing, nibble select and blanking decision for the next output update.
  always_comb begin
    tick_c      = (refresh_cnt == CNT_LAST);
    frame_end_c = tick_c && (digit_idx == IDX_LAST);
    nibble_c    = 4'h0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (digit_idx == IDX_W'(k)) nibble_c = disp[4*k +: 4];
    end
    blank_c = ov && blink;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    top_idx_c = '0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (disp[4*k +: 4] != 4'h0) top_idx_c = IDX_W'(k);
    end
    if (digit_idx > top_idx_c) blank_c = 1'b1;
`endif
  end

  // Counters, shadow/display registers; display only changes on the frame-end edge.
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      refresh_cnt <= '0;
      digit_idx   <= '0;
      frame_cnt   <= '0;
      blink       <= 1'b0;
      shadow      <= '0;
      shadow_ov   <= 1'b0;
      disp        <= '0;
      ov          <= 1'b0;
      pending     <= 1'b0;
    end else begin
      refresh_cnt <= tick_c ? '0 : refresh_cnt + CNT_W'(1);
      if (tick_c) digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
      if (frame_end_c) begin
        if (frame_cnt == FRM_LAST) begin
          frame_cnt <= '0;
          blink     <= ~blink;
        end else begin
          frame_cnt <= frame_cnt + FRM_W'(1);
        end
      end
      if (dm_write) begin
        shadow    <= data_in;
        shadow_ov <= ov_in;
      end
      if (dm_write && frame_end_c) begin
        disp    <= data_in;
        ov      <= ov_in;
        pending <= 1'b0;
      end else if (dm_write) begin
        pending <= 1'b1;
      end else if (frame_end_c && pending) begin
        disp    <= shadow;
        ov      <= shadow_ov;
        pending <= 1'b0;
      end
    end
  end

  // Registered segment/digit drive, dark while in reset.
  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      seg   <= 7'b1111111;
      digit <= '1;
    end else begin
      seg   <= hex_to_seg(nibble_c);
      digit <= blank_c ? '1 : ~(NUM_DIGITS'(1) << digit_idx);
    end
  end

endmodule

// File: doc/bf16_seg_scan_ctrl.md
BF16_SEG_SCAN_CTRL -- requirements
Module: bf16_seg_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 Parameter REFRESH_DIV, default 100000: clk_100MHz cycles per digit slot, minimum 2.
REQ-003 Parameter BLINK_FRAMES, default 250: scan frames per blink half-period, minimum 1.
REQ-004 clk_100MHz  input  1  single system clock; all state rising-edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 dm_write  input  1  one-cycle load strobe for data_in and ov_in.
REQ-007 data_in  input  4*NUM_DIGITS  hex value; nibble k drives digit k, nibble 0 rightmost.
REQ-008 ov_in  input  1  overflow flag sampled with data_in.
REQ-009 seg  output  [0:6]  active-low segments; seg[0]=a through seg[6]=g.
REQ-010 digit  output  NUM_DIGITS  active-low digit enables, at most one low.
REQ-011 ov  output  1  overflow flag of the value currently displayed.
REQ-012 pending  output  1  high while a written value waits for frame end.

Function
REQ-013 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; terminal count advances the digit index.
REQ-014 Digit index SHALL count 0..NUM_DIGITS-1 and wrap to 0; the wrap cycle is "frame end".
REQ-015 seg and digit SHALL be registered, changing exactly 1 cycle after the index changes.
REQ-016 dm_write SHALL load shadow register and shadow ov from data_in/ov_in and set pending.
REQ-017 At frame end with pending=1, display register and ov SHALL load from shadow and pending SHALL clear (tear-free update).
REQ-018 dm_write coincident with frame end SHALL load data_in/ov_in directly into display register and ov; pending SHALL end low.
REQ-019 Back-to-back dm_write before frame end: last write wins, pending stays high.
REQ-020 Hex encoding (a..g, 0=lit): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
REQ-021 Frame counter SHALL count frame ends 0..BLINK_FRAMES-1 and wrap; wrap toggles blink phase.
REQ-022 With ov=1 and blink phase=1, digit SHALL be all 1s; scanning and counters continue.
REQ-023 With ov=0, blink phase SHALL be ignored; all digits scan normally.
REQ-024 ov falling to 0 mid-blank SHALL restore normal scanning at the next registered output update.

Reset
REQ-025 Reset assertion SHALL immediately force digit to all 1s and seg to 1111111, independent of clock.
REQ-026 Reset SHALL clear refresh counter, digit index, frame counter, blink phase, shadow, display register, ov and pending to 0.
REQ-027 Reset asserted mid-frame or with pending=1 SHALL discard the pending value.
REQ-028 After release, first valid output SHALL be digit 0 showing "0", one cycle after the first rising edge.

Configuration
REQ-029 Macro SEG_LEADING_ZERO_BLANK_EN defined: digits above the highest non-zero nibble SHALL be blanked (digit bit held 1); digit 0 always shown.
REQ-030 Macro SEG_LEADING_ZERO_BLANK_EN undefined: all NUM_DIGITS digits SHALL display, including leading zeros.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, BLINK_FRAMES=2)
REQ-031 Release reset, no writes -> digit cycles 1110,1101,1011,0111 every 4 clocks, seg=0000001 throughout, ov=0.
REQ-032 dm_write data_in=0x3FA1 mid-frame -> pending=1, display unchanged until frame end, then digits show 1,A,F,3; pending=0.
REQ-033 dm_write 0x1111 then 0x2222 in same frame -> only 2222 ever displayed.
REQ-034 dm_write 0x0005, ov_in=1, at frame end -> ov=1 next cycle; digits blank for 2 frames, lit for 2 frames, repeating.
REQ-035 Assert reset with pending=1 mid-frame -> digit=1111, seg=1111111 asynchronously; after release shows 0000, pending=0.
REQ-036 SEG_LEADING_ZERO_BLANK_EN defined, display 0x0070 -> digits 2 and 3 stay 1; digits 0,1 show 0,7.
